// File: rtl/gray_to_rgb565_ise.sv
// Custom-instruction responder: expands four packed 8-bit gray pixels to RGB565.
// A CONVERT call returns pixels 0-1 and buffers pixels 2-3. A READ_HI call
// returns the buffered pixels. A STATUS call reports whether the buffer holds
// unread data.
module gray_to_rgb565_ise #(
  parameter logic [7:0] customInstructionId = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [7:0]  iseId,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    StIdle,
    StStage,
    StRespond
  } state_e;

  localparam logic [1:0] ModeConvert = 2'd0;
  localparam logic [1:0] ModeReadHi  = 2'd1;
  localparam logic [1:0] ModeStatus  = 2'd2;

  state_e      state_q, state_d;
  logic [31:0] op_q, op_d;
  logic [31:0] hi_buf_q, hi_buf_d;
  logic        hi_valid_q, hi_valid_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;

  logic       accept;
  logic [1:0] mode;

  // Only the low two bits of operand B carry meaning.
  logic unused_value_b;
  assign unused_value_b = ^valueB[31:2];

  assign mode   = valueB[1:0];
  assign accept = start && (iseId == customInstructionId) && (state_q == StIdle);

  // Bit-replication expansion: no rounding, the top gray bits feed each channel.
  function automatic logic [15:0] gray_to_rgb(input logic [7:0] g);
    return {g[7:3], g[7:2], g[7:3]};
  endfunction

  // State and datapath registers; reset clears everything and aborts a call.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= 32'd0;
      hi_buf_q   <= 32'd0;
      hi_valid_q <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      hi_buf_q   <= hi_buf_d;
      hi_valid_q <= hi_valid_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (mode == ModeConvert) ? StStage : StRespond;
        end
      end
      StStage:   state_d = StRespond;
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output and datapath next values; result_d stays zero unless done_d is set.
  always_comb begin
    op_d       = op_q;
    hi_buf_d   = hi_buf_q;
    hi_valid_d = hi_valid_q;
    done_d     = 1'b0;
    result_d   = 32'd0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (mode)
            ModeConvert: op_d = valueA;
            ModeReadHi: begin
              done_d     = 1'b1;
              result_d   = hi_valid_q ? hi_buf_q : 32'd0;
              hi_valid_d = 1'b0;
            end
            ModeStatus: begin
              done_d   = 1'b1;
              result_d = {31'd0, hi_valid_q};
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      StStage: begin
        done_d     = 1'b1;
        result_d   = {gray_to_rgb(op_q[15:8]), gray_to_rgb(op_q[7:0])};
        hi_buf_d   = {gray_to_rgb(op_q[31:24]), gray_to_rgb(op_q[23:16])};
        hi_valid_d = 1'b1;
      end
      StRespond: ;
      default: ;
    endcase
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_gray_to_rgb565_ise.sv
// Self-checking bench for gray_to_rgb565_ise: directed vector table, reset-abort
// sequence, then randomized calls checked against a behavioural model.
module tb_gray_to_rgb565_ise;

  localparam logic [7:0] Id = 8'h5A;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] valueA = 32'd0;
  logic [31:0] valueB = 32'd0;
  logic [7:0]  iseId = 8'd0;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  gray_to_rgb565_ise #(
    .customInstructionId(Id)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .valueA (valueA),
    .valueB (valueB),
    .iseId  (iseId),
    .done   (done),
    .result (result)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [31:0] a;
    logic [7:0]  id;
    logic        exp_done;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state.
  logic [31:0] m_hi;
  bit          m_hv;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] m_rgb(input int g);
    int r5;
    int g6;
    r5 = g / 8;
    g6 = g / 4;
    return 16'(r5 * 2048 + g6 * 32 + r5);
  endfunction

  // Predicts a call's outcome and updates the model buffer.
  task automatic model_call(input logic [1:0] mode, input logic [31:0] a, input logic [7:0] id,
                            output logic exp_done, output logic [31:0] exp_res);
    exp_done = (id == Id);
    exp_res  = 32'd0;
    if (exp_done) begin
      case (mode)
        2'd0: begin
          exp_res = {m_rgb(int'(a[15:8])), m_rgb(int'(a[7:0]))};
          m_hi    = {m_rgb(int'(a[31:24])), m_rgb(int'(a[23:16]))};
          m_hv    = 1'b1;
        end
        2'd1: begin
          exp_res = m_hv ? m_hi : 32'd0;
          m_hv    = 1'b0;
        end
        2'd2: exp_res = {31'd0, m_hv};
        default: exp_res = 32'd0;
      endcase
    end
  endtask

  // Issues one call and watches four cycles for done, its latency and value.
  task automatic run_call(input string name, input logic [1:0] mode, input logic [31:0] a,
                          input logic [7:0] id, input logic exp_done, input logic [31:0] exp_res);
    int          lat;
    int          exp_lat;
    logic [31:0] got;
    logic        stray;
    logic [31:0] rb;
    rb = $urandom();
    @(negedge clock);
    start  = 1'b1;
    valueA = a;
    valueB = {rb[31:2], mode};
    iseId  = id;
    @(negedge clock);
    start = 1'b0;
    lat   = 0;
    got   = 32'd0;
    stray = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (done && lat == 0) begin
        lat = c;
        got = result;
      end else if (done || result != 32'd0) begin
        stray = 1'b1;
      end
      if (c < 4) @(negedge clock);
    end
    exp_lat = !exp_done ? 0 : (mode == 2'd0 ? 2 : 1);
    check({name, " latency"}, lat, exp_lat);
    if (exp_done) check({name, " result"}, got, exp_res);
    check({name, " quiet"}, {31'd0, stray}, 32'd0);
  endtask

  task automatic add_vec(input string name, input logic [1:0] mode, input logic [31:0] a,
                         input logic [7:0] id, input logic exp_done, input logic [31:0] exp_res);
    vec_t v;
    v.name = name; v.mode = mode; v.a = a; v.id = id;
    v.exp_done = exp_done; v.exp_res = exp_res;
    vecs.push_back(v);
  endtask

  initial begin
    logic        e_done;
    logic [31:0] e_res;
    logic        bad;

    add_vec("status_reset",  2'd2, 32'h0,        Id,    1'b1, 32'h0000_0000);
    add_vec("convert_mix",   2'd0, 32'h80FF0010, Id,    1'b1, 32'h0000_1082);
    add_vec("read_hi_mix",   2'd1, 32'h0,        Id,    1'b1, 32'h8410_FFFF);
    add_vec("status_clear",  2'd2, 32'h0,        Id,    1'b1, 32'h0000_0000);
    add_vec("read_hi_empty", 2'd1, 32'h0,        Id,    1'b1, 32'h0000_0000);
    add_vec("convert_ones",  2'd0, 32'hFFFFFFFF, Id,    1'b1, 32'hFFFF_FFFF);
    add_vec("badid_read",    2'd1, 32'h0,        8'h00, 1'b0, 32'h0);
    add_vec("badid_conv",    2'd0, 32'h00000000, 8'h5B, 1'b0, 32'h0);
    add_vec("badid_status",  2'd2, 32'h0,        8'hA5, 1'b0, 32'h0);
    add_vec("badid_rsvd",    2'd3, 32'h0,        8'hFF, 1'b0, 32'h0);
    add_vec("status_kept",   2'd2, 32'h0,        Id,    1'b1, 32'h0000_0001);
    add_vec("read_hi_ones",  2'd1, 32'h0,        Id,    1'b1, 32'hFFFF_FFFF);
    add_vec("reserved",      2'd3, 32'h12345678, Id,    1'b1, 32'h0000_0000);
    add_vec("convert_zero",  2'd0, 32'h00000000, Id,    1'b1, 32'h0000_0000);
    add_vec("convert_10",    2'd0, 32'h10101010, Id,    1'b1, 32'h1082_1082);
    add_vec("read_hi_ovw",   2'd1, 32'h0,        Id,    1'b1, 32'h1082_1082);
    add_vec("status_final",  2'd2, 32'h0,        Id,    1'b1, 32'h0000_0000);

    // Reset, then five idle cycles with quiet outputs.
    m_hi = 32'd0;
    m_hv = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (done || result != 32'd0) bad = 1'b1;
    end
    check("idle_after_reset", {31'd0, bad}, 32'd0);

    // Directed table; the model tracks along so the random phase stays in sync.
    foreach (vecs[i]) begin
      model_call(vecs[i].mode, vecs[i].a, vecs[i].id, e_done, e_res);
      run_call(vecs[i].name, vecs[i].mode, vecs[i].a, vecs[i].id, vecs[i].exp_done,
               vecs[i].exp_res);
    end

    // Fill the buffer, then abort a CONVERT in STAGE with reset.
    run_call("pre_abort_conv", 2'd0, 32'hC0C0C0C0, Id, 1'b1, 32'hC618_C618);
    @(negedge clock);
    start  = 1'b1;
    valueA = 32'hFFFFFFFF;
    valueB = 32'd0;
    iseId  = Id;
    @(negedge clock);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_hi = 32'd0;
    m_hv = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (done || result != 32'd0) bad = 1'b1;
      @(negedge clock);
    end
    check("abort_no_done", {31'd0, bad}, 32'd0);
    run_call("status_after_abort", 2'd2, 32'h0, Id, 1'b1, 32'h0000_0000);

    // Randomized calls against the model.
    for (int n = 0; n < 150; n++) begin
      logic [1:0]  mode;
      logic [31:0] a;
      logic [7:0]  id;
      mode = 2'($urandom_range(0, 3));
      a    = $urandom();
      id   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : Id;
      model_call(mode, a, id, e_done, e_res);
      run_call("random", mode, a, id, e_done, e_res);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
